// File: rtl/apb_cmd_master.sv
// APB requester: converts a valid/ready command stream into APB SETUP/ACCESS
// transfers, returns one response per command on a valid/ready channel, and
// aborts transfers to a slave that never raises PREADY.
module apb_cmd_master #(
    parameter int ADDR_W  = 8,
    parameter int DATA_W  = 8,
    parameter int TIMEOUT = 16
) (
    input  logic              pclk,
    input  logic              preset_n,
    // command channel
    input  logic              cmd_valid,
    output logic              cmd_ready,
    input  logic              cmd_write,
    input  logic [ADDR_W-1:0] cmd_addr,
    input  logic [DATA_W-1:0] cmd_wdata,
    // response channel
    output logic              rsp_valid,
    input  logic              rsp_ready,
    output logic [DATA_W-1:0] rsp_rdata,
    output logic              rsp_err,
    output logic              rsp_timeout,
    // APB requester side
    output logic              psel,
    output logic              penable,
    output logic              pwrite,
    output logic [ADDR_W-1:0] paddr,
    output logic [DATA_W-1:0] pwdata,
    input  logic [DATA_W-1:0] prdata,
    input  logic              pready,
    input  logic              pslverr
);

    localparam logic [1:0] ST_IDLE   = 2'd0;
    localparam logic [1:0] ST_SETUP  = 2'd1;
    localparam logic [1:0] ST_ACCESS = 2'd2;
    localparam logic [1:0] ST_RESP   = 2'd3;

    // Watchdog counts completed wait cycles 0..TIMEOUT-1; TIMEOUT=0 disables it.
    localparam int               CNT_W    = (TIMEOUT > 1) ? $clog2(TIMEOUT) : 1;
    localparam logic [CNT_W-1:0] CNT_LAST = (TIMEOUT > 0) ? CNT_W'(TIMEOUT - 1) : '0;
    localparam bit               WDOG_EN  = (TIMEOUT > 0);

    logic [1:0]        state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              psel_q, psel_d;
    logic              penable_q, penable_d;
    logic              pwrite_q, pwrite_d;
    logic [ADDR_W-1:0] paddr_q, paddr_d;
    logic [DATA_W-1:0] pwdata_q, pwdata_d;
    logic              rsp_valid_q, rsp_valid_d;
    logic [DATA_W-1:0] rsp_rdata_q, rsp_rdata_d;
    logic              rsp_err_q, rsp_err_d;
    logic              rsp_timeout_q, rsp_timeout_d;

    logic wdog_expire;

    // The current wait cycle is the TIMEOUT-th one without PREADY.
    assign wdog_expire = WDOG_EN && (cnt_q == CNT_LAST);

    // Next-state logic for the command -> SETUP -> ACCESS -> response sequence
    always_comb begin
        // NOTE: every _d defaults to its _q so no path through the case infers a latch.
        state_d       = state_q;
        cnt_d         = cnt_q;
        psel_d        = psel_q;
        penable_d     = penable_q;
        pwrite_d      = pwrite_q;
        paddr_d       = paddr_q;
        pwdata_d      = pwdata_q;
        rsp_valid_d   = rsp_valid_q;
        rsp_rdata_d   = rsp_rdata_q;
        rsp_err_d     = rsp_err_q;
        rsp_timeout_d = rsp_timeout_q;

        case (state_q)
            ST_IDLE: begin
                if (cmd_valid) begin
                    pwrite_d = cmd_write;
                    paddr_d  = cmd_addr;
                    pwdata_d = cmd_wdata;
                    psel_d   = 1'b1;
                    state_d  = ST_SETUP;
                end
            end
            ST_SETUP: begin
                penable_d = 1'b1;
                cnt_d     = '0;
                state_d   = ST_ACCESS;
            end
            ST_ACCESS: begin
                if (pready) begin
                    // Normal completion; PREADY wins over a simultaneous expiry.
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = pwrite_q ? '0 : prdata;
                    rsp_err_d     = pslverr;
                    rsp_timeout_d = 1'b0;
                    state_d       = ST_RESP;
                end else if (wdog_expire) begin
                    psel_d        = 1'b0;
                    penable_d     = 1'b0;
                    rsp_valid_d   = 1'b1;
                    rsp_rdata_d   = '0;
                    rsp_err_d     = 1'b1;
                    rsp_timeout_d = 1'b1;
                    state_d       = ST_RESP;
                end else begin
                    cnt_d = cnt_q + CNT_W'(1);
                end
            end
            ST_RESP: begin
                if (rsp_ready) begin
                    rsp_valid_d = 1'b0;
                    state_d     = ST_IDLE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    // State and output registers; reset drops the bus and discards any response
    always_ff @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            state_q       <= ST_IDLE;
            cnt_q         <= '0;
            psel_q        <= 1'b0;
            penable_q     <= 1'b0;
            pwrite_q      <= 1'b0;
            paddr_q       <= '0;
            pwdata_q      <= '0;
            rsp_valid_q   <= 1'b0;
            rsp_rdata_q   <= '0;
            rsp_err_q     <= 1'b0;
            rsp_timeout_q <= 1'b0;
        end else begin
            // NOTE: non-blocking updates so every register samples pre-edge values.
            state_q       <= state_d;
            cnt_q         <= cnt_d;
            psel_q        <= psel_d;
            penable_q     <= penable_d;
            pwrite_q      <= pwrite_d;
            paddr_q       <= paddr_d;
            pwdata_q      <= pwdata_d;
            rsp_valid_q   <= rsp_valid_d;
            rsp_rdata_q   <= rsp_rdata_d;
            rsp_err_q     <= rsp_err_d;
            rsp_timeout_q <= rsp_timeout_d;
        end
    end

    assign cmd_ready   = (state_q == ST_IDLE);
    assign psel        = psel_q;
    assign penable     = penable_q;
    assign pwrite      = pwrite_q;
    assign paddr       = paddr_q;
    assign pwdata      = pwdata_q;
    assign rsp_valid   = rsp_valid_q;
    assign rsp_rdata   = rsp_rdata_q;
    assign rsp_err     = rsp_err_q;
    assign rsp_timeout = rsp_timeout_q;

endmodule

// File: tb/tb_apb_cmd_master.sv
// Bench for apb_cmd_master: directed transfers against a transaction-level
// model that predicts bus and response outputs every cycle.
module tb_apb_cmd_master;

    localparam int AW = 8;
    localparam int DW = 8;
    localparam int TO = 4;

    logic          pclk = 1'b0;
    logic          preset_n = 1'b0;
    logic          cmd_valid = 1'b0;
    logic          cmd_ready;
    logic          cmd_write = 1'b0;
    logic [AW-1:0] cmd_addr = '0;
    logic [DW-1:0] cmd_wdata = '0;
    logic          rsp_valid;
    logic          rsp_ready = 1'b1;
    logic [DW-1:0] rsp_rdata;
    logic          rsp_err;
    logic          rsp_timeout;
    logic          psel;
    logic          penable;
    logic          pwrite;
    logic [AW-1:0] paddr;
    logic [DW-1:0] pwdata;
    logic [DW-1:0] prdata = 8'hC3;
    logic          pready = 1'b0;
    logic          pslverr = 1'b0;

    int cyc   = 0;
    int n_vec = 0;
    int n_bad = 0;

    apb_cmd_master #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
        .pclk(pclk), .preset_n(preset_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_write(cmd_write),
        .cmd_addr(cmd_addr), .cmd_wdata(cmd_wdata),
        .rsp_valid(rsp_valid), .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .rsp_timeout(rsp_timeout),
        .psel(psel), .penable(penable), .pwrite(pwrite), .paddr(paddr),
        .pwdata(pwdata), .prdata(prdata), .pready(pready), .pslverr(pslverr)
    );

    always #5 pclk = ~pclk;
    always @(posedge pclk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (cycle %0d)", name, got, exp, cyc);
        end
    endtask

    // Transaction model: a command is either absent, on the bus (t=1 is the
    // select-only cycle, t>=2 the enabled cycles) or waiting as a response.
    bit         m_busy = 1'b0;
    bit         m_resp = 1'b0;
    int         m_t    = 0;
    logic       m_wr;
    logic [7:0] m_addr, m_wdata, m_rdata;
    logic       m_err, m_to;

    always @(posedge pclk or negedge preset_n) begin
        if (!preset_n) begin
            m_busy <= 1'b0;
            m_resp <= 1'b0;
            m_t    <= 0;
        end else if (m_resp) begin
            if (rsp_ready) m_resp <= 1'b0;
        end else if (m_busy) begin
            if (m_t == 1) begin
                m_t <= 2;
            end else if (pready) begin
                m_busy  <= 1'b0;
                m_resp  <= 1'b1;
                m_rdata <= m_wr ? 8'h00 : prdata;
                m_err   <= pslverr;
                m_to    <= 1'b0;
            end else if (TO != 0 && m_t - 1 == TO) begin
                m_busy  <= 1'b0;
                m_resp  <= 1'b1;
                m_rdata <= 8'h00;
                m_err   <= 1'b1;
                m_to    <= 1'b1;
            end else begin
                m_t <= m_t + 1;
            end
        end else if (cmd_valid) begin
            m_busy  <= 1'b1;
            m_t     <= 1;
            m_wr    <= cmd_write;
            m_addr  <= cmd_addr;
            m_wdata <= cmd_wdata;
        end
    end

    // Per-cycle comparison against the model, mid-cycle
    always @(negedge pclk) begin
        if (preset_n) begin
            check("psel", psel, m_busy);
            check("penable", penable, m_busy && m_t >= 2);
            check("cmd_ready", cmd_ready, !m_busy && !m_resp);
            check("rsp_valid", rsp_valid, m_resp);
            if (m_busy) begin
                check("paddr", paddr, m_addr);
                check("pwrite", pwrite, m_wr);
                if (m_wr) check("pwdata", pwdata, m_wdata);
            end
            if (m_resp) begin
                check("rsp_rdata", rsp_rdata, m_rdata);
                check("rsp_err", rsp_err, m_err);
                check("rsp_timeout", rsp_timeout, m_to);
            end
        end
    end

    // Present a command and wait for it to be accepted; returns after the accept edge.
    task automatic send(input logic wr, input logic [7:0] a, input logic [7:0] d, output int c_acc);
        bit ok;
        ok        = 1'b0;
        c_acc     = -1;
        cmd_write = wr;
        cmd_addr  = a;
        cmd_wdata = d;
        cmd_valid = 1'b1;
        for (int i = 0; i < 50 && !ok; i++) begin
            @(negedge pclk);
            if (cmd_ready) begin
                @(posedge pclk);
                #1;
                c_acc = cyc;
                ok    = 1'b1;
            end
        end
        cmd_valid = 1'b0;
        if (!ok) check("accept_bound", 32'd0, 32'd1);
    endtask

    // Slave side: called in the select-only cycle; holds PREADY low for n_wait
    // enabled cycles, or until the watchdog limit, and returns after the final edge.
    task automatic slave(input int n_wait, input bit err, input logic [7:0] rd,
                         input bit setup_err, input bit wait_err, output int n_acc);
        pslverr = setup_err;
        @(posedge pclk);
        #1;
        n_acc = 0;
        for (int k = 0; k < 64; k++) begin
            pready  = (k == n_wait);
            pslverr = pready ? err : wait_err;
            prdata  = pready ? rd : 8'hEE;
            @(posedge pclk);
            #1;
            n_acc = k + 1;
            if (pready || k + 1 == TO) break;
        end
        pready  = 1'b0;
        pslverr = 1'b0;
        prdata  = 8'hC3;
    endtask

    // Consumer side: called in the first response cycle; stalls for hold cycles.
    task automatic drain(input int hold, input int c_acc, output int lat,
                         output logic [7:0] rd, output logic er, output logic to, output int c_hs);
        lat       = cyc - c_acc + 1;
        rd        = rsp_rdata;
        er        = rsp_err;
        to        = rsp_timeout;
        rsp_ready = (hold == 0);
        repeat (hold) begin
            @(posedge pclk);
            #1;
        end
        rsp_ready = 1'b1;
        @(posedge pclk);
        #1;
        c_hs = cyc;
    endtask

    initial begin
        #100000;
        $display("FAIL sim_time_bound: bench did not finish");
        $fatal(1, "time bound exceeded");
    end

    initial begin
        int         ca, ca2, na, lat, chs;
        logic [7:0] rd;
        logic       er, to;

        // Reset state
        repeat (3) @(posedge pclk);
        #1;
        check("rst_psel", psel, 1'b0);
        check("rst_penable", penable, 1'b0);
        check("rst_pwrite", pwrite, 1'b0);
        check("rst_paddr", paddr, 8'h00);
        check("rst_pwdata", pwdata, 8'h00);
        check("rst_rsp_valid", rsp_valid, 1'b0);
        check("rst_rsp_fields", {rsp_rdata, rsp_err, rsp_timeout}, 10'h000);
        #2 preset_n = 1'b1;
        @(posedge pclk);
        #1;
        check("idle_cmd_ready", cmd_ready, 1'b1);

        // Write, zero-wait slave
        send(1'b1, 8'h03, 8'hA5, ca);
        slave(0, 1'b0, 8'hFF, 1'b0, 1'b0, na);
        drain(0, ca, lat, rd, er, to, chs);
        check("wr_latency", lat, 3);
        check("wr_access_cycles", na, 1);
        check("wr_rdata", rd, 8'h00);
        check("wr_err", er, 1'b0);

        // Read, 3 wait states, pslverr noise on the wait cycles
        send(1'b0, 8'h05, 8'h00, ca);
        slave(3, 1'b0, 8'h5A, 1'b0, 1'b1, na);
        check("model_rd_rdata", m_rdata, 8'h5A);
        drain(0, ca, lat, rd, er, to, chs);
        check("rd_latency", lat, 6);
        check("rd_access_cycles", na, 4);
        check("rd_rdata", rd, 8'h5A);
        check("rd_err", er, 1'b0);

        // Slave error at completion
        send(1'b0, 8'h08, 8'h00, ca);
        slave(0, 1'b1, 8'h12, 1'b0, 1'b0, na);
        drain(0, ca, lat, rd, er, to, chs);
        check("slverr_err", er, 1'b1);
        check("slverr_timeout", to, 1'b0);
        check("slverr_rdata", rd, 8'h12);

        // pslverr only during SETUP is ignored
        send(1'b0, 8'h08, 8'h00, ca);
        slave(0, 1'b0, 8'h34, 1'b1, 1'b0, na);
        drain(0, ca, lat, rd, er, to, chs);
        check("setup_err_ignored", er, 1'b0);

        // Watchdog expiry: pready stuck low
        send(1'b0, 8'h0C, 8'h00, ca);
        slave(100, 1'b0, 8'h77, 1'b0, 1'b0, na);
        check("model_to_flag", m_to, 1'b1);
        check("to_psel_dropped", {psel, penable}, 2'b00);
        drain(0, ca, lat, rd, er, to, chs);
        check("to_access_cycles", na, TO);
        check("to_latency", lat, 6);
        check("to_fields", {rd, er, to}, {8'h00, 1'b1, 1'b1});

        // pready on the last allowed cycle wins over the watchdog
        send(1'b0, 8'h0D, 8'h00, ca);
        slave(TO - 1, 1'b0, 8'h3C, 1'b0, 1'b0, na);
        drain(0, ca, lat, rd, er, to, chs);
        check("edge_access_cycles", na, TO);
        check("edge_fields", {rd, er, to}, {8'h3C, 1'b0, 1'b0});

        // Response backpressure, then a back-to-back command held valid
        send(1'b1, 8'h10, 8'h77, ca);
        cmd_write = 1'b0;
        cmd_addr  = 8'h20;
        cmd_wdata = 8'h00;
        cmd_valid = 1'b1;
        slave(0, 1'b0, 8'hFF, 1'b0, 1'b0, na);
        drain(5, ca, lat, rd, er, to, chs);
        check("bp_fields", {rd, er, to}, 10'h000);
        send(1'b0, 8'h20, 8'h00, ca2);
        check("b2b_accept_gap", ca2 - chs, 1);
        slave(1, 1'b0, 8'h99, 1'b0, 1'b0, na);
        drain(0, ca2, lat, rd, er, to, chs);
        check("b2b_rdata", rd, 8'h99);
        check("b2b_latency", lat, 4);

        // Reset during ACCESS, command offered while in reset
        send(1'b1, 8'h40, 8'hBB, ca);
        @(posedge pclk);
        #1;
        check("pre_rst_penable", penable, 1'b1);
        #2 preset_n = 1'b0;
        #1;
        check("async_rst_bus", {psel, penable, rsp_valid}, 3'b000);
        cmd_write = 1'b1;
        cmd_addr  = 8'h55;
        cmd_wdata = 8'h66;
        cmd_valid = 1'b1;
        @(posedge pclk);
        #1;
        check("rst_no_accept", psel, 1'b0);
        cmd_valid = 1'b0;
        #2 preset_n = 1'b1;
        #1;
        check("post_rst_cmd_ready", cmd_ready, 1'b1);
        @(posedge pclk);
        #1;
        send(1'b1, 8'h01, 8'h11, ca);
        slave(0, 1'b0, 8'hFF, 1'b0, 1'b0, na);
        drain(0, ca, lat, rd, er, to, chs);
        check("post_rst_latency", lat, 3);
        check("post_rst_fields", {rd, er, to}, 10'h000);

        repeat (2) @(posedge pclk);
        #1;
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule

// File: doc/apb_cmd_master.md
Name: apb_cmd_master

Overview:
- Upstream APB requester for the 8-register APB peripheral slaves in this codebase.
- Converts a simple valid/ready command stream (write/read, address, data) into compliant APB SETUP/ACCESS transfers.
- Captures PRDATA/PSLVERR and returns one response per command on a valid/ready response channel.
- Adds a PREADY watchdog so a hung or absent slave cannot stall the command source.

Parameters:
ADDR_W, 8, APB address width (paddr, cmd_addr)
DATA_W, 8, APB data width (pwdata, prdata, cmd_wdata, rsp_rdata)
TIMEOUT, 16, max ACCESS-phase cycles waiting for pready; 0 disables the watchdog

Ports:
pclk  input  1  clock, all logic on rising edge
preset_n  input  1  asynchronous active-low reset
cmd_valid  input  1  command present
cmd_ready  output  1  block can accept a command
cmd_write  input  1  1=write, 0=read
cmd_addr  input  ADDR_W  target address
cmd_wdata  input  DATA_W  write data (ignored for reads)
rsp_valid  output  1  response present
rsp_ready  input  1  consumer accepts response
rsp_rdata  output  DATA_W  read data (0 for writes and timeouts)
rsp_err  output  1  pslverr seen or timeout
rsp_timeout  output  1  transfer aborted by watchdog
psel  output  1  APB select
penable  output  1  APB enable
pwrite  output  1  APB direction
paddr  output  ADDR_W  APB address
pwdata  output  DATA_W  APB write data
prdata  input  DATA_W  APB read data
pready  input  1  APB ready
pslverr  input  1  APB error

Behaviour:
- Clock and reset: one clock domain (pclk). preset_n is asynchronous, active-low.
- Reset values: all registered outputs are 0 (psel, penable, pwrite, paddr, pwdata, rsp_valid, rsp_rdata, rsp_err, rsp_timeout), state=IDLE, watchdog counter=0.
- FSM states:
  - IDLE: cmd_ready=1 (combinational, state==IDLE). On cmd_valid&cmd_ready, latch cmd_write/addr/wdata into pwrite/paddr/pwdata and go to SETUP.
  - SETUP (1 cycle): psel=1, penable=0. Next cycle goes to ACCESS.
  - ACCESS: psel=1, penable=1. paddr/pwrite/pwdata are held stable from SETUP through the end of ACCESS. The transfer completes at the rising edge where pready=1. At that edge:
    - rsp_rdata <= prdata for reads, 0 for writes.
    - rsp_err <= pslverr; rsp_timeout <= 0.
    - psel, penable <= 0.
    - Go to RESP.
  - RESP: rsp_valid=1; rsp_* fields held stable until the rsp_valid&rsp_ready edge, then return to IDLE. rsp_valid deasserts the cycle after the handshake. cmd_ready stays 0 throughout SETUP, ACCESS and RESP (one outstanding transfer only).
- Latency with a zero-wait slave (pready=1 in the first ACCESS cycle):
  - Command accepted at edge 0.
  - psel=1 in cycle 1, penable=1 in cycle 2.
  - rsp_valid=1 in cycle 3.
  - Each wait-state cycle (pready=0) adds one cycle.
- Watchdog:
  - Counter clears on entering ACCESS and increments every ACCESS cycle with pready=0.
  - When the count reaches TIMEOUT with pready still 0: drop psel/penable, set rsp_err=1, rsp_timeout=1, rsp_rdata=0, go to RESP.
  - If pready=1 in the cycle the count reaches TIMEOUT, the transfer completes normally (pready wins).
  - TIMEOUT=0: the counter never expires.
- pslverr is sampled only at the completing edge (psel&penable&pready). It is ignored in SETUP and in ACCESS cycles with pready=0.
- Back-to-back commands: a new command is accepted at the earliest one cycle after the response handshake (IDLE visited for ≥1 cycle). psel therefore drops for ≥2 cycles between transfers.
- rsp_ready held high: RESP lasts exactly one cycle.
- Reset mid-transfer: psel/penable drop to 0 immediately (asynchronously), the in-flight command and any pending response are discarded, and the FSM returns to IDLE. No response is ever produced for a transfer interrupted by reset.
- Commands presented while preset_n=0 are not accepted.

Test Plan:
- Write, zero-wait slave: cmd write addr=0x03 data=0xA5 -> psel in cycle 1, penable in cycle 2, paddr=0x03, pwdata=0xA5 stable across both cycles; rsp_valid in cycle 3 with rsp_err=0, rsp_rdata=0x00.
- Read with 3 wait states: slave holds pready=0 for 3 ACCESS cycles, then pready=1 with prdata=0x5A -> ACCESS lasts 4 cycles; rsp_rdata=0x5A, rsp_err=0.
- Slave error: read addr=0x08, slave returns pready=1, pslverr=1 -> rsp_err=1, rsp_timeout=0. pslverr pulsed during SETUP only -> rsp_err=0.
- Timeout: TIMEOUT=4, pready stuck at 0 -> psel/penable drop after 4 ACCESS cycles; rsp_err=1, rsp_timeout=1, rsp_rdata=0. Repeat with pready=1 on the 4th cycle -> normal completion, rsp_timeout=0.
- Response backpressure and back-to-back: rsp_ready=0 for 5 cycles -> rsp fields stable and cmd_ready=0 throughout. Second cmd_valid held high -> accepted one cycle after the handshake, with no psel overlap between transfers.
- Reset in ACCESS: deassert preset_n during penable=1 -> psel=penable=rsp_valid=0 with no clock edge required. After release, cmd_ready=1, and the next write (addr 0x01, data 0x11) completes normally.
